// File: rtl/fp_sqrt_seq_if.sv
// Operand/result handshake bundle for the sequential square-root unit.
interface fp_sqrt_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [2:0]   in_rm;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_invalid;
    logic         out_inexact;

    modport master (
        output in_valid, in_data, in_rm, out_ready,
        input  in_ready, out_valid, out_data, out_invalid, out_inexact
    );

    modport slave (
        input  in_valid, in_data, in_rm, out_ready,
        output in_ready, out_valid, out_data, out_invalid, out_inexact
    );
endinterface

// File: rtl/fp_sqrt_seq.sv
// fp_sqrt_seq: sequential IEEE-754 square root. Radix-2 restoring digit
// recurrence, one root bit per cycle, one operation in flight at a time.
module fp_sqrt_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_sqrt_seq_if.slave bus
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int N      = MAN_W + 3;          // hidden + fraction + guard + round
    localparam int CW     = $clog2(N + 1);
    localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
    localparam int LAST_I = N - 1;
    localparam logic [EXP_W:0] BIAS = BIAS_I[EXP_W:0];
    localparam logic [CW-1:0]  LAST = LAST_I[CW-1:0];
    localparam logic [W-1:0]   QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, ROUND = 2'd2, DONE = 2'd3;

    logic [1:0]       state;
    logic [2:0]       rm;
    logic             sp, sp_inv;
    logic [W-1:0]     sp_res;
    logic [EXP_W-1:0] exp_r;
    logic [2*N-1:0]   rad;
    logic [N:0]       rem;
    logic [N-1:0]     root;
    logic [CW-1:0]    cnt;
    logic             ov, oinv, oinx;
    logic [W-1:0]     od;

    logic             i_sign, i_zero, i_max, i_odd, i_sp, i_inv;
    logic [EXP_W-1:0] i_exp;
    logic [MAN_W-1:0] i_frac;
    logic [W-1:0]     i_res;
    logic [EXP_W:0]   i_esum;
    logic [MAN_W+1:0] i_m;

    assign i_sign = bus.in_data[W-1];
    assign i_exp  = bus.in_data[W-2 -: EXP_W];
    assign i_frac = bus.in_data[MAN_W-1:0];
    assign i_zero = (i_exp == '0);
    assign i_max  = &i_exp;
    // BIAS is odd, so the unbiased exponent is odd exactly when the stored one is even
    assign i_odd  = ~i_exp[0];
    assign i_m    = i_odd ? {1'b1, i_frac, 1'b0} : {1'b0, 1'b1, i_frac};
    // (E-BIAS-odd)/2 + BIAS == (E+BIAS-odd)/2, and that sum is always even and non-negative
    assign i_esum = {1'b0, i_exp} + BIAS - {{EXP_W{1'b0}}, i_odd};

    // classify the offered operand; denormals count as zero with sign kept
    always_comb begin
        i_sp  = 1'b1;
        i_inv = 1'b0;
        i_res = QNAN;
        if (i_zero)
            i_res = {i_sign, {(W-1){1'b0}}};
        else if (i_max && |i_frac)
            i_inv = ~i_frac[MAN_W-1];
        else if (i_sign)
            i_inv = 1'b1;
        else if (i_max)
            i_res = bus.in_data;
        else
            i_sp = 1'b0;
    end

    // one restoring step: bring down two radicand bits, try root*4+1
    logic [N+2:0] rem_sh, trial, diff;
    logic         ge;
    assign rem_sh = {rem, rad[2*N-1 -: 2]};
    assign trial  = {1'b0, root, 2'b01};
    assign ge     = (rem_sh >= trial);
    assign diff   = rem_sh - trial;

    // rounding of the finished root; the result is always positive
    logic             g, st, inc;
    logic [MAN_W+1:0] mant;
    logic [EXP_W-1:0] r_exp;
    assign g  = root[1];
    assign st = (|rem) | root[0];

    // increment decision per rounding mode; unused codes fall back to RNE
    always_comb begin
        inc = g & (st | root[2]);
        case (rm)
            3'b001, 3'b010: inc = 1'b0;
            3'b011:         inc = g | st;
            3'b100:         inc = g;
            default:        inc = g & (st | root[2]);
        endcase
    end

    assign mant  = {1'b0, root[N-1:2]} + {{(MAN_W+1){1'b0}}, inc};
    // carry-out leaves the fraction bits at zero, so only the exponent moves
    assign r_exp = exp_r + {{(EXP_W-1){1'b0}}, mant[MAN_W+1]};

    logic unused_bits;
    assign unused_bits = ^{diff[N+2:N+1], rem_sh[N+2:N+1], i_esum[0], mant[MAN_W]};

    // control FSM plus datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rm     <= '0;
            sp     <= 1'b0;
            sp_inv <= 1'b0;
            sp_res <= '0;
            exp_r  <= '0;
            rad    <= '0;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
            ov     <= 1'b0;
            oinv   <= 1'b0;
            oinx   <= 1'b0;
            od     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    rm     <= bus.in_rm;
                    sp     <= i_sp;
                    sp_inv <= i_inv;
                    sp_res <= i_res;
                    exp_r  <= i_esum[EXP_W:1];
                    rad    <= {i_m, {(MAN_W+4){1'b0}}};
                    rem    <= '0;
                    root   <= '0;
                    cnt    <= '0;
                    // specials take one registered hop through ROUND to the output
                    state  <= i_sp ? ROUND : CALC;
                end
                CALC: begin
                    rem   <= ge ? diff[N:0] : rem_sh[N:0];
                    root  <= {root[N-2:0], ge};
                    rad   <= {rad[2*N-3:0], 2'b00};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) state <= ROUND;
                end
                ROUND: begin
                    ov    <= 1'b1;
                    od    <= sp ? sp_res : {1'b0, r_exp, mant[MAN_W-1:0]};
                    oinv  <= sp & sp_inv;
                    oinx  <= ~sp & (g | st);
                    state <= DONE;
                end
                default: if (bus.out_ready) begin
                    ov    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = ov;
    assign bus.out_data    = od;
    assign bus.out_invalid = oinv;
    assign bus.out_inexact = oinx;
endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Self-checking bench for fp_sqrt_seq: single- and double-precision instances
// checked against an exact integer-square-root reference model.
module tb_fp_sqrt_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fp_sqrt_seq_if #(.EXP_W(8),  .MAN_W(23)) b32 ();
    fp_sqrt_seq_if #(.EXP_W(11), .MAN_W(52)) b64 ();

    fp_sqrt_seq #(.EXP_W(8),  .MAN_W(23)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    fp_sqrt_seq #(.EXP_W(11), .MAN_W(52)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    // exact reference: root scaled to mw fraction bits, then exact guard/sticky
    function automatic void ref_sqrt(input logic [63:0] x, input int ew, input int mw,
                                     input logic [2:0] rm, output logic [63:0] res,
                                     output logic inv, output logic inx);
        logic         s, g, st, up;
        logic [63:0]  e, f, emax, bias;
        logic [127:0] y, t, h, y4;
        int           ee;
        s    = x[ew+mw];
        emax = (64'd1 << ew) - 1;
        bias = (64'd1 << (ew-1)) - 1;
        e    = (x >> mw) & emax;
        f    = x & ((64'd1 << mw) - 1);
        res  = (emax << mw) | (64'd1 << (mw-1));
        inv  = 1'b0;
        inx  = 1'b0;
        if (e == 0) res = s ? (64'd1 << (ew+mw)) : 64'd0;
        else if (e == emax && f != 0) inv = ~f[mw-1];
        else if (s) inv = 1'b1;
        else if (e == emax) res = x;
        else begin
            ee = int'(e) - int'(bias);
            y  = {64'd0, (64'd1 << mw) | f};
            if (ee % 2 != 0) begin y = y << 1; ee = ee - 1; end
            y = y << mw;
            t = '0;
            for (int b = 63; b >= 0; b--) begin
                h = t | (128'd1 << b);
                if (h * h <= y) t = h;
            end
            y4  = y << 2;
            h   = (t << 1) + 128'd1;
            inx = (t * t != y);
            g   = (y4 >= h * h);
            st  = inx && (y4 != h * h);
            case (rm)
                3'd1, 3'd2: up = 1'b0;
                3'd3:       up = g | st;
                3'd4:       up = g;
                default:    up = g & (st | t[0]);
            endcase
            t  = t + {127'd0, up};
            ee = ee / 2 + int'(bias);
            if (t[mw+1]) begin ee = ee + 1; t = t >> 1; end
            res = (64'(ee) << mw) | (t[63:0] & ((64'd1 << mw) - 1));
        end
    endfunction

    function automatic int exp_lat(input logic [63:0] x, input int ew, input int mw);
        logic [63:0] e;
        e = (x >> mw) & ((64'd1 << ew) - 1);
        if (x[ew+mw] || e == 0 || e == (64'd1 << ew) - 1) return 1;
        return mw + 4;
    endfunction

    task automatic run32(input logic [31:0] x, input logic [2:0] rm, output logic [31:0] d,
                         output logic inv, output logic inx, output int lat);
        int w;
        w = 0;
        while (!b32.in_ready && w < 100) begin @(negedge clk); w++; end
        b32.in_valid = 1'b1; b32.in_data = x; b32.in_rm = rm;
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0; b32.in_data = $urandom; b32.in_rm = 3'($urandom);
        lat = 0;
        while (!b32.out_valid && lat < 100) begin @(negedge clk); lat++; end
        d = b32.out_data; inv = b32.out_invalid; inx = b32.out_inexact;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run64(input logic [63:0] x, input logic [2:0] rm, output logic [63:0] d,
                         output logic inv, output logic inx, output int lat);
        int w;
        w = 0;
        while (!b64.in_ready && w < 100) begin @(negedge clk); w++; end
        b64.in_valid = 1'b1; b64.in_data = x; b64.in_rm = rm;
        @(posedge clk);
        @(negedge clk);
        b64.in_valid = 1'b0; b64.in_data = {$urandom, $urandom}; b64.in_rm = 3'($urandom);
        lat = 0;
        while (!b64.out_valid && lat < 100) begin @(negedge clk); lat++; end
        d = b64.out_data; inv = b64.out_invalid; inx = b64.out_inexact;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++; if (b32.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", b32.in_ready); end
        n_cmp++; if (b32.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", b32.out_valid); end
        n_cmp++; if (b32.out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", b32.out_data); end
        n_cmp++; if ({b32.out_invalid, b32.out_inexact} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {b32.out_invalid, b32.out_inexact}); end
        n_cmp++; if (b64.out_data !== 64'h0) begin n_bad++; $display("FAIL reset_out_data64 got %h want 0", b64.out_data); end
    endtask

    task automatic test_exact();
        logic [31:0] xs [0:1], ys [0:1], d;
        logic iv, ix;
        int lat;
        xs = '{32'h40800000, 32'h41100000};
        ys = '{32'h40000000, 32'h40400000};
        for (int i = 0; i < 2; i++) begin
            run32(xs[i], 3'b000, d, iv, ix, lat);
            n_cmp++; if (d !== ys[i]) begin n_bad++; $display("FAIL exact_data x=%h got %h want %h", xs[i], d, ys[i]); end
            n_cmp++; if ({iv, ix} !== 2'b00) begin n_bad++; $display("FAIL exact_flags x=%h got %b want 00", xs[i], {iv, ix}); end
            n_cmp++; if (lat !== 27) begin n_bad++; $display("FAIL exact_latency x=%h got %0d want 27", xs[i], lat); end
        end
    endtask

    task automatic test_round();
        logic [2:0]  rms [0:2];
        logic [31:0] ys [0:2], d;
        logic [63:0] r;
        logic iv, ix, eiv, eix;
        int lat;
        rms = '{3'b000, 3'b001, 3'b011};
        ys  = '{32'h3FB504F3, 32'h3FB504F3, 32'h3FB504F4};
        for (int i = 0; i < 3; i++) begin
            run32(32'h40000000, rms[i], d, iv, ix, lat);
            n_cmp++; if (d !== ys[i]) begin n_bad++; $display("FAIL round_data rm=%0d got %h want %h", rms[i], d, ys[i]); end
            n_cmp++; if ({iv, ix} !== 2'b01) begin n_bad++; $display("FAIL round_flags rm=%0d got %b want 01", rms[i], {iv, ix}); end
        end
        for (int m = 2; m < 8; m++) begin
            if (m == 3) continue;
            run32(32'h40000000, 3'(m), d, iv, ix, lat);
            ref_sqrt(64'h40000000, 8, 23, 3'(m), r, eiv, eix);
            n_cmp++; if ({d, iv, ix} !== {r[31:0], eiv, eix}) begin n_bad++; $display("FAIL round_model rm=%0d got %h/%b%b want %h/%b%b", m, d, iv, ix, r[31:0], eiv, eix); end
        end
    endtask

    task automatic test_special();
        logic [31:0] xs [0:5], ys [0:5], d;
        logic        vs [0:5];
        logic iv, ix;
        int lat;
        xs = '{32'hC2F86B85, 32'h80000000, 32'h7F800000, 32'h7F800001, 32'hFFC00000, 32'h00000001};
        ys = '{32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000};
        vs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run32(xs[i], 3'b000, d, iv, ix, lat);
            n_cmp++; if (d !== ys[i]) begin n_bad++; $display("FAIL special_data x=%h got %h want %h", xs[i], d, ys[i]); end
            n_cmp++; if ({iv, ix} !== {vs[i], 1'b0}) begin n_bad++; $display("FAIL special_flags x=%h got %b want %b0", xs[i], {iv, ix}, vs[i]); end
            n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL special_latency x=%h got %0d want 1", xs[i], lat); end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, d;
        logic [63:0] r;
        logic [2:0]  rm;
        logic iv, ix, eiv, eix;
        int lat, k;
        for (int i = 0; i < 60; i++) begin
            x = $urandom;
            k = $urandom_range(0, 9);
            if (k == 0) x[30:23] = 8'h00;
            if (k == 1) x[30:23] = 8'hFF;
            if ($urandom_range(0, 9) < 8) x[31] = 1'b0;
            rm = 3'($urandom);
            run32(x, rm, d, iv, ix, lat);
            ref_sqrt({32'd0, x}, 8, 23, rm, r, eiv, eix);
            n_cmp++; if ({d, iv, ix} !== {r[31:0], eiv, eix}) begin n_bad++; $display("FAIL random x=%h rm=%0d got %h/%b%b want %h/%b%b", x, rm, d, iv, ix, r[31:0], eiv, eix); end
            n_cmp++; if (lat !== exp_lat({32'd0, x}, 8, 23)) begin n_bad++; $display("FAIL random_latency x=%h got %0d want %0d", x, lat, exp_lat({32'd0, x}, 8, 23)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        int lat, bad;
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.in_data = 32'h41100000; b32.in_rm = 3'b000;
        @(posedge clk);
        @(negedge clk);
        b32.in_data = 32'h40800000;
        lat = 0;
        while (!b32.out_valid && lat < 100) begin @(negedge clk); lat++; end
        n_cmp++; if (lat !== 27) begin n_bad++; $display("FAIL bp_latency got %0d want 27", lat); end
        held = b32.out_data;
        n_cmp++; if (held !== 32'h40400000) begin n_bad++; $display("FAIL bp_data got %h want 40400000", held); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b32.out_data !== held || b32.out_valid !== 1'b1 || b32.in_ready !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        b32.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({b32.out_valid, b32.in_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_handshake got v=%b r=%b want v=0 r=1", b32.out_valid, b32.in_ready); end
        @(negedge clk);
        b32.in_valid = 1'b0;
        n_cmp++; if (b32.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_second_accept got in_ready=%b want 0", b32.in_ready); end
        lat = 0;
        while (!b32.out_valid && lat < 100) begin @(negedge clk); lat++; end
        n_cmp++; if ({lat, b32.out_data} !== {32'd27, 32'h40000000}) begin n_bad++; $display("FAIL bp_second got lat=%0d %h want lat=27 40000000", lat, b32.out_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic iv, ix;
        int lat, stale;
        b32.in_valid = 1'b1; b32.in_data = 32'h40000000; b32.in_rm = 3'b000;
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({b32.out_valid, b32.in_ready, b32.out_data} !== {2'b01, 32'h0}) begin n_bad++; $display("FAIL rst_mid_async got v=%b r=%b d=%h want v=0 r=1 d=0", b32.out_valid, b32.in_ready, b32.out_data); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({b32.out_valid, b32.in_ready} !== 2'b01) begin n_bad++; $display("FAIL rst_mid_release got v=%b r=%b want v=0 r=1", b32.out_valid, b32.in_ready); end
        stale = 0;
        repeat (30) begin @(negedge clk); if (b32.out_valid) stale++; end
        n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL rst_mid_stale got %0d valid cycles want 0", stale); end
        run32(32'h40800000, 3'b000, d, iv, ix, lat);
        n_cmp++; if (d !== 32'h40000000) begin n_bad++; $display("FAIL rst_mid_next got %h want 40000000", d); end
        // reset while a result is being held must drop it at once
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.in_data = 32'h40000000; b32.in_rm = 3'b011;
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0;
        lat = 0;
        while (!b32.out_valid && lat < 100) begin @(negedge clk); lat++; end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({b32.out_valid, b32.out_invalid, b32.out_inexact, b32.out_data} !== 35'h0) begin n_bad++; $display("FAIL rst_done_async got v=%b f=%b%b d=%h want all 0", b32.out_valid, b32.out_invalid, b32.out_inexact, b32.out_data); end
        @(negedge clk); rst_n = 1'b1; b32.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_double();
        logic [63:0] x, d, r;
        logic [2:0]  rm;
        logic iv, ix, eiv, eix;
        int lat;
        run64(64'h4000000000000000, 3'b000, d, iv, ix, lat);
        n_cmp++; if (d !== 64'h3FF6A09E667F3BCD) begin n_bad++; $display("FAIL dbl_sqrt2 got %h want 3ff6a09e667f3bcd", d); end
        n_cmp++; if ({iv, ix} !== 2'b01) begin n_bad++; $display("FAIL dbl_flags got %b want 01", {iv, ix}); end
        n_cmp++; if (lat !== 56) begin n_bad++; $display("FAIL dbl_latency got %0d want 56", lat); end
        for (int i = 0; i < 12; i++) begin
            x = {$urandom, $urandom};
            if (i < 10) x[63] = 1'b0;
            rm = 3'($urandom);
            run64(x, rm, d, iv, ix, lat);
            ref_sqrt(x, 11, 52, rm, r, eiv, eix);
            n_cmp++; if ({d, iv, ix} !== {r, eiv, eix}) begin n_bad++; $display("FAIL dbl_random x=%h rm=%0d got %h/%b%b want %h/%b%b", x, rm, d, iv, ix, r, eiv, eix); end
            n_cmp++; if (lat !== exp_lat(x, 11, 52)) begin n_bad++; $display("FAIL dbl_random_latency x=%h got %0d want %0d", x, lat, exp_lat(x, 11, 52)); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        b32.in_valid = 1'b0; b32.in_data = '0; b32.in_rm = '0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_data = '0; b64.in_rm = '0; b64.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_exact();
        test_round();
        test_special();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_double();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
